// File: rtl/riscv_defines.sv
// Shared types for the fetch-side branch predictor:
// BHT counter states and the BTB entry layout.
package riscv_defines;

   localparam int BTB_ENTRIES_DEFAULT = 16;
   localparam int BP_XLEN_MAX = 32;
   localparam int BP_TAG_MAX  = 30;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bht_state_t;

   typedef struct packed {
      logic                   valid;
      logic [BP_TAG_MAX-1:0]  tag;
      logic [BP_XLEN_MAX-1:0] target;
      bht_state_t             state;
   } btb_entry_t;

   localparam btb_entry_t BTB_RST = '{
      valid:  1'b0,
      tag:    '0,
      target: '0,
      state:  WEAK_NT
   };

endpackage

// File: rtl/bht_counter.sv
// 2-bit saturating counter next-state function.
// Pure combinational; used on the training path.
module bht_counter
   import riscv_defines::*;
(
   input  bht_state_t i_state,
   input  logic       i_taken,
   output bht_state_t o_state
);

   // saturate at STRONG_T going up, STRONG_NT going down
   always_comb begin
      o_state = i_state;
      if (i_taken) begin
         if (i_state != STRONG_T)
            o_state = bht_state_t'(i_state + 2'd1);
      end else begin
         if (i_state != STRONG_NT)
            o_state = bht_state_t'(i_state - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: IF lookup,
// EX training, mispredict/redirect and perf counters.
module branch_predictor
   import riscv_defines::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = BTB_ENTRIES_DEFAULT,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc_f,
   output logic            pred_taken_f,
   output logic [XLEN-1:0] pred_pc_f,
   input  logic            update_valid_e,
   input  logic [XLEN-1:0] update_pc_e,
   input  logic            update_taken_e,
   input  logic [XLEN-1:0] update_target_e,
   input  logic            pred_taken_e,
   input  logic [XLEN-1:0] pred_pc_e,
   output logic            mispredict_e,
   output logic [XLEN-1:0] redirect_pc_e,
   output logic [31:0]     lookup_cnt,
   output logic [31:0]     mispredict_cnt
);

   localparam int TAG_W = XLEN - IDX_W - 2;

   btb_entry_t r_tab [ENTRIES];
   logic [31:0] r_lk_cnt;
   logic [31:0] r_mis_cnt;

   logic [IDX_W-1:0] w_idx_f;
   logic [TAG_W-1:0] w_tag_f;
   btb_entry_t       w_rd_f;
   logic             w_hit_f;

   logic [IDX_W-1:0] w_idx_e;
   logic [TAG_W-1:0] w_tag_e;
   btb_entry_t       w_rd_e;
   logic             w_hit_e;
   bht_state_t       w_nxt_e;
   btb_entry_t       w_alloc;
   logic [XLEN-1:0]  w_seq_e;

   logic w_unused;

   assign w_idx_f = pc_f[IDX_W+1:2];
   assign w_tag_f = pc_f[XLEN-1:IDX_W+2];
   assign w_rd_f  = r_tab[w_idx_f];
   assign w_hit_f = w_rd_f.valid &&
                    (w_rd_f.tag[TAG_W-1:0] == w_tag_f);

   assign pred_taken_f = w_hit_f && w_rd_f.state[1];
   assign pred_pc_f    = pred_taken_f ?
                         w_rd_f.target[XLEN-1:0] :
                         pc_f + XLEN'(4);

   assign w_idx_e = update_pc_e[IDX_W+1:2];
   assign w_tag_e = update_pc_e[XLEN-1:IDX_W+2];
   assign w_rd_e  = r_tab[w_idx_e];
   assign w_hit_e = w_rd_e.valid &&
                    (w_rd_e.tag[TAG_W-1:0] == w_tag_e);
   assign w_seq_e = update_pc_e + XLEN'(4);

   assign redirect_pc_e = update_taken_e ?
                          update_target_e : w_seq_e;
   assign mispredict_e  = update_valid_e &&
                          (pred_pc_e != redirect_pc_e);

   assign lookup_cnt     = r_lk_cnt;
   assign mispredict_cnt = r_mis_cnt;

   assign w_unused = ^{pc_f[1:0], update_pc_e[1:0],
                       pred_taken_e,
                       w_rd_f.tag[BP_TAG_MAX-1:TAG_W],
                       w_rd_e.tag[BP_TAG_MAX-1:TAG_W]};

   bht_counter u_bht (
      .i_state (w_rd_e.state),
      .i_taken (update_taken_e),
      .o_state (w_nxt_e)
   );

   // fresh entry for a taken branch that missed
   always_comb begin
      w_alloc = BTB_RST;
      w_alloc.valid = 1'b1;
      w_alloc.tag[TAG_W-1:0] = w_tag_e;
      w_alloc.target[XLEN-1:0] = update_target_e;
      w_alloc.state = WEAK_T;
   end

   // table training: update on hit, allocate on taken miss
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++)
            r_tab[i] <= BTB_RST;
      end else if (update_valid_e) begin
         if (w_hit_e) begin
            r_tab[w_idx_e].state <= w_nxt_e;
            if (update_taken_e)
               r_tab[w_idx_e].target[XLEN-1:0] <=
                  update_target_e;
         end else if (update_taken_e) begin
            r_tab[w_idx_e] <= w_alloc;
         end
      end
   end

   // perf counters, free-running and wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lk_cnt  <= '0;
         r_mis_cnt <= '0;
      end else begin
         if (update_valid_e)
            r_lk_cnt <= r_lk_cnt + 32'd1;
         if (mispredict_e)
            r_mis_cnt <= r_mis_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver pushes
// expectations from an abstract BTB model, monitor compares.
module tb_branch_predictor;

   localparam int ENT   = 16;
   localparam int IDX_W = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_f = '0;
   logic        pred_taken_f;
   logic [31:0] pred_pc_f;
   logic        update_valid_e = 1'b0;
   logic [31:0] update_pc_e = '0;
   logic        update_taken_e = 1'b0;
   logic [31:0] update_target_e = '0;
   logic        pred_taken_e = 1'b0;
   logic [31:0] pred_pc_e = '0;
   logic        mispredict_e;
   logic [31:0] redirect_pc_e;
   logic [31:0] lookup_cnt;
   logic [31:0] mispredict_cnt;

   branch_predictor #(.XLEN(32), .ENTRIES(ENT)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc_f            (pc_f),
      .pred_taken_f    (pred_taken_f),
      .pred_pc_f       (pred_pc_f),
      .update_valid_e  (update_valid_e),
      .update_pc_e     (update_pc_e),
      .update_taken_e  (update_taken_e),
      .update_target_e (update_target_e),
      .pred_taken_e    (pred_taken_e),
      .pred_pc_e       (pred_pc_e),
      .mispredict_e    (mispredict_e),
      .redirect_pc_e   (redirect_pc_e),
      .lookup_cnt      (lookup_cnt),
      .mispredict_cnt  (mispredict_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pt;
      logic [31:0] pp;
      logic        mis;
      logic [31:0] rd;
      logic [31:0] lc;
      logic [31:0] mc;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_pass = 0;

   // reference model: plain arrays, counter as 0..3
   bit          m_v   [ENT];
   logic [31:0] m_tag [ENT];
   logic [31:0] m_tgt [ENT];
   int          m_cnt [ENT];
   logic [31:0] m_lc;
   logic [31:0] m_mc;

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % ENT);
   endfunction

   function automatic logic [31:0] tag_of(logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      int i = idx_of(pc);
      return m_v[i] && (m_tag[i] == tag_of(pc));
   endfunction

   function automatic logic [31:0] m_pred(logic [31:0] pc);
      int i = idx_of(pc);
      if (m_hit(pc) && m_cnt[i] >= 2) return m_tgt[i];
      return pc + 32'd4;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < ENT; i++) begin
         m_v[i] = 0;
         m_cnt[i] = 1;
         m_tag[i] = '0;
         m_tgt[i] = '0;
      end
      m_lc = '0;
      m_mc = '0;
   endtask

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h",
                    nm, act, req);
   endtask

   // one cycle: drive, push expectation, advance model
   task automatic step(logic [31:0] pcf, bit uv,
                       logic [31:0] upc, bit ut,
                       logic [31:0] utgt,
                       logic [31:0] ppe);
      exp_t e;
      logic [31:0] corr;
      int i;
      @(posedge clk);
      #1;
      pc_f = pcf;
      update_valid_e = uv;
      update_pc_e = upc;
      update_taken_e = ut;
      update_target_e = utgt;
      pred_pc_e = ppe;
      pred_taken_e = (ppe != upc + 32'd4);
      corr = ut ? utgt : upc + 32'd4;
      e.pp  = m_pred(pcf);
      e.pt  = (e.pp != pcf + 32'd4) ||
              (m_hit(pcf) && m_cnt[idx_of(pcf)] >= 2);
      e.mis = uv && (ppe != corr);
      e.rd  = corr;
      e.lc  = m_lc;
      e.mc  = m_mc;
      q.push_back(e);
      if (uv) begin
         i = idx_of(upc);
         m_lc = m_lc + 32'd1;
         if (e.mis) m_mc = m_mc + 32'd1;
         if (m_hit(upc)) begin
            if (ut) begin
               m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
               m_tgt[i] = utgt;
            end else begin
               m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
         end else if (ut) begin
            m_v[i] = 1;
            m_tag[i] = tag_of(upc);
            m_tgt[i] = utgt;
            m_cnt[i] = 2;
         end
      end
   endtask

   task automatic idle(logic [31:0] pcf);
      step(pcf, 0, 32'h0, 0, 32'h0, 32'h4);
   endtask

   // monitor: outputs are valid every cycle, compare mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && q.size() != 0) begin
         e = q.pop_front();
         chk("pred_taken_f", 32'(pred_taken_f), 32'(e.pt));
         chk("pred_pc_f", pred_pc_f, e.pp);
         chk("mispredict_e", 32'(mispredict_e), 32'(e.mis));
         chk("redirect_pc_e", redirect_pc_e, e.rd);
         chk("lookup_cnt", lookup_cnt, e.lc);
         chk("mispredict_cnt", mispredict_cnt, e.mc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] upc, pcf, tgt, ppe;
      bit ut;
      m_reset();
      #12;
      rst_n = 1'b1;

      idle(32'h100);
      // allocate with same-cycle lookup of 0x100
      step(32'h100, 1, 32'h100, 1, 32'h200, 32'h104);
      idle(32'h100);
      for (int k = 0; k < 3; k++)
         step(32'h100, 1, 32'h100, 1, 32'h200, 32'h200);
      step(32'h100, 1, 32'h100, 0, 32'h200, 32'h200);
      step(32'h100, 1, 32'h100, 0, 32'h200, 32'h200);
      idle(32'h100);
      // alias at index 0
      step(32'h100, 1, 32'h100, 1, 32'h200, 32'h104);
      step(32'h140, 1, 32'h140, 1, 32'h300, 32'h144);
      idle(32'h100);
      idle(32'h140);
      idle(32'hFFFF_FFFC);

      // async reset between edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("rst_pred_taken", 32'(pred_taken_f), 32'd0);
      chk("rst_pred_pc", pred_pc_f, pc_f + 32'd4);
      chk("rst_lookup_cnt", lookup_cnt, 32'd0);
      chk("rst_mis_cnt", mispredict_cnt, 32'd0);
      pc_f = 32'h140;
      #1;
      chk("rst_alias_gone", pred_pc_f, 32'h144);
      update_valid_e = 1'b1;
      update_pc_e = 32'h180;
      update_taken_e = 1'b1;
      update_target_e = 32'h400;
      @(posedge clk);
      #1;
      update_valid_e = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      idle(32'h180);
      idle(32'h140);

      // mispredict counter wrap
      step(32'h0, 1, 32'h40, 1, 32'h80, 32'h44);
      idle(32'h0);
      @(negedge clk);
      #1;
      force dut.r_mis_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_mis_cnt;
      m_mc = 32'hFFFF_FFFF;
      step(32'h0, 1, 32'h40, 0, 32'h80, 32'h80);
      idle(32'h0);

      // randomized traffic over a small aliasing address set
      for (int k = 0; k < 400; k++) begin
         upc = (32'($urandom_range(0, 3)) << 6) |
               (32'($urandom_range(0, 15)) << 2);
         pcf = (32'($urandom_range(0, 3)) << 6) |
               (32'($urandom_range(0, 15)) << 2);
         tgt = {$urandom} & 32'hFFFF_FFFC;
         ut  = $urandom_range(0, 1) == 1;
         ppe = ($urandom_range(0, 9) < 7) ?
               m_pred(upc) : ({$urandom} & 32'hFFFC);
         step(pcf, $urandom_range(0, 3) != 0,
              upc, ut, tgt, ppe);
      end
      idle(32'h0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
